alu_cp_buffer: RTL and testbench
================================

# alu_cp_buffer

Per-functional-unit result buffer on the execute side of the complete stage. It captures ALU results as `EX_CP_PACKET`s and presents them to `cp_stage`, one entry per cycle in FIFO order. When `cp_stage` does not grant a CDB slot, the head is held for a later cycle. When the buffer fills, it back-pressures issue. One instance sits behind each ALU; its output drives `ex_cp_packet_alu0` or `ex_cp_packet_alu1`, and its stall input comes from `ALU0_stall_out` or `ALU1_stall_out`.

## Interface
- `DEPTH`, default 2: number of buffered packets. Power of two, at least 2.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `ex_packet_in`  in  `EX_CP_PACKET`: ALU result; `.valid` qualifies it.
- `cp_stall_in`  in  1: from `cp_stage`. 1 means the head was not granted this cycle.
- `squash_in`  in  1: mispredict flush.
- `ex_cp_packet_out`  out  `EX_CP_PACKET`: head entry. Reads as all-zero (`.valid`=0) when empty.
- `stall_out`  out  1: buffer full. Issue must not launch into this ALU while it is 1.
- `count_out`  out  `$clog2(DEPTH+1)`: occupancy, for debug/perf.

## Operation
- Storage is a circular array of `DEPTH` packets with `head`/`tail` pointers of width `$clog2(DEPTH)` and `count` of width `$clog2(DEPTH+1)`.
- Pointers wrap modulo `DEPTH`.
- **Enqueue** occurs when `ex_packet_in.valid && !stall_out && !squash_in`. The packet is written at `tail`, and `tail` increments.
- **Dequeue** occurs when `ex_cp_packet_out.valid && !cp_stall_in && !squash_in`. `head` increments.
- **Occupancy update:** `count` changes by enqueue minus dequeue.
  - Simultaneous enqueue and dequeue leaves `count` unchanged.
  - When full, a same-cycle dequeue does not permit an enqueue, because `stall_out` depends only on `count`.
- `stall_out = (count == DEPTH)`. It is a pure function of registers and has no combinational path from any input.
- **Input while full:** `ex_packet_in.valid=1` while `stall_out=1` is a protocol violation. The packet is dropped and state is unchanged; a simulation-only assertion fires.
- **Output contents:** `ex_cp_packet_out` is the stored head entry when `count>0`, otherwise zero. It has no combinational path from `ex_packet_in`, which is required to avoid a loop with `cp_stage`'s combinational stall.
- **Squash:** `squash_in=1` sets `head=tail=count=0` at the edge and discards any same-cycle input. A squash takes priority over enqueue and dequeue.
- **Reset:** `head=tail=count=0` and storage is cleared. Outputs are zero, `stall_out=0`, `count_out=0`. Reset asserted mid-operation discards all contents immediately and asynchronously.
- Ordering is strict FIFO. Packet contents (Tag, value, etc.) pass through unmodified.

## Timing
- Latency is 1 cycle: a packet accepted at edge N is visible on `ex_cp_packet_out` after edge N. There is no empty-bypass.
- A head not granted (`cp_stall_in=1`) stays stable, bit-identical, until granted or squashed.
- A granted head is replaced by the next entry, or by zero, after the same edge.
- `stall_out` rises after the edge that makes `count==DEPTH`. It falls after the first edge with a dequeue.
- Sustained throughput is 1 packet/cycle when `cp_stall_in=0`.

## Structure
- `EX_CP_PACKET` and `CDB_PACKET` stay in the shared `sys_defs` package. No new typedefs are needed.
- No sub-module. Pointer and counter logic is inline, because the buffer is the sub-module.
- `cp_stage` is unchanged; the top level instantiates two copies of this block.

## Test plan
- **Reset:** assert `reset` mid-run with `count=2` -> outputs zero, `stall_out=0`, `count_out=0` before the next edge.
- **Pass-through:** enqueue Tag=3 with `cp_stall_in=0` -> Tag=3 appears the next cycle, valid for exactly 1 cycle, then `count_out=0`.
- **Hold:** enqueue Tag=3 then Tag=4 with `cp_stall_in=1` -> output stays Tag=3 and `stall_out=1` after the second edge. Release the stall -> Tag=3, then Tag=4 on consecutive cycles.
- **Full plus simultaneous dequeue:** full, `cp_stall_in=0`, input Tag=5 valid -> Tag=5 dropped, assertion fires, `count_out` goes 2->1.
- **Wrap-around:** stream 8 packets, Tags 1..8, with the stall toggling each cycle -> all 8 emerge in order with no duplicates.
- **Squash:** `squash_in=1` with `count=2` and a valid input Tag=9 -> next cycle the output is invalid, `count_out=0`, and Tag=9 never appears.

Source files
------------

// File: rtl/sys_defs.sv
// Shared pipeline packet types for the execute/complete boundary.
// EX_CP_PACKET carries one functional-unit result toward the CDB.
package sys_defs;

   localparam int XLEN      = 32;
   localparam int PRF_IDX_W = 6;
   localparam int ROB_IDX_W = 5;

   typedef struct packed {
      logic [XLEN-1:0]      npc;
      logic [XLEN-1:0]      value;
      logic [PRF_IDX_W-1:0] tag;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic                 take_branch;
      logic                 halt;
      logic                 valid;
   } EX_CP_PACKET;

   typedef struct packed {
      logic [PRF_IDX_W-1:0] tag;
      logic [XLEN-1:0]      value;
      logic                 valid;
   } CDB_PACKET;

endpackage

// File: rtl/alu_cp_buffer.sv
// Per-ALU result FIFO between execute and cp_stage: holds ungranted results
// in order and back-pressures issue when full.
module alu_cp_buffer
   import sys_defs::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  EX_CP_PACKET                ex_packet_in,
   input  logic                       cp_stall_in,
   input  logic                       squash_in,
   output EX_CP_PACKET                ex_cp_packet_out,
   output logic                       stall_out,
   output logic [$clog2(DEPTH+1)-1:0] count_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   EX_CP_PACKET        mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               enq;
   logic               deq;

   // Handshake: upstream offers ex_packet_in.valid and may only do so while
   // stall_out is 0; the head is consumed on a cycle where it is valid and
   // cp_stall_in is 0. Both flags derive from registers, so no loop forms.
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign stall_out = full;
   assign count_out = count;

   assign ex_cp_packet_out = empty ? '0 : mem[head];

   assign enq = ex_packet_in.valid && !full && !squash_in;
   assign deq = !empty && !cp_stall_in && !squash_in;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (squash_in) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            mem[tail] <= ex_packet_in;
            tail      <= tail + 1'b1;
         end
         if (deq) begin
            head <= head + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A squashed input is discarded anyway, so only flag live offers.
   always @(posedge clock) begin
      if (!reset && !squash_in) begin
         assert (!(ex_packet_in.valid && full))
            else $warning("alu_cp_buffer: input offered while full, packet dropped");
      end
   end

endmodule

// File: tb/tb_alu_cp_buffer.sv
// Directed bench for alu_cp_buffer: vector table for the single-step cases,
// plus hand sequences for asynchronous reset and a wrapping stream.
module tb_alu_cp_buffer;
   import sys_defs::*;

   localparam int DEPTH = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   EX_CP_PACKET ex_packet_in;
   logic        cp_stall_in;
   logic        squash_in;
   EX_CP_PACKET ex_cp_packet_out;
   logic        stall_out;
   logic [1:0]  count_out;

   int checks = 0;
   int errors = 0;

   alu_cp_buffer #(.DEPTH(DEPTH)) dut (
      .clock            (clock),
      .reset            (reset),
      .ex_packet_in     (ex_packet_in),
      .cp_stall_in      (cp_stall_in),
      .squash_in        (squash_in),
      .ex_cp_packet_out (ex_cp_packet_out),
      .stall_out        (stall_out),
      .count_out        (count_out)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       in_valid;
      logic [5:0] in_tag;
      logic       cp_stall;
      logic       squash;
      logic       exp_valid;
      logic [5:0] exp_tag;
      logic [1:0] exp_count;
      logic       exp_stall;
   } vec_t;

   vec_t      vecs [21];
   logic [5:0] exp_q [$];

   function automatic EX_CP_PACKET make_pkt(input logic [5:0] tag);
      EX_CP_PACKET p;
      p             = '0;
      p.npc         = 32'h0000_1000 + {24'd0, tag, 2'b00};
      p.value       = 32'hA5A5_0000 | {26'd0, tag};
      p.tag         = tag;
      p.rob_idx     = tag[4:0];
      p.take_branch = tag[0];
      p.valid       = 1'b1;
      return p;
   endfunction

   function automatic vec_t row(input int iv, input int it, input int cs, input int sq,
                                input int ev, input int et, input int ec, input int es);
      vec_t v;
      v.in_valid  = iv[0];
      v.in_tag    = 6'(it);
      v.cp_stall  = cs[0];
      v.squash    = sq[0];
      v.exp_valid = ev[0];
      v.exp_tag   = 6'(et);
      v.exp_count = 2'(ec);
      v.exp_stall = es[0];
      return v;
   endfunction

   task automatic check_pkt(input string name, input EX_CP_PACKET act, input EX_CP_PACKET exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got packet %h (tag %0d valid %0d), expected %h (tag %0d valid %0d)",
                  name, act, act.tag, act.valid, exp, exp.tag, exp.valid);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [5:0] tag, input logic cs, input logic sq);
      ex_packet_in = iv ? make_pkt(tag) : '0;
      cp_stall_in  = cs;
      squash_in    = sq;
   endtask

   initial begin
      int popped;
      int next_tag;
      int model_cnt;
      int cyc;
      logic enq;
      logic deq;

      // pass-through, hold, full with dequeue, squash, simultaneous enq/deq
      vecs[0]  = row(1,  3, 0, 0, 1,  3, 1, 0);
      vecs[1]  = row(0,  0, 0, 0, 0,  0, 0, 0);
      vecs[2]  = row(1,  3, 1, 0, 1,  3, 1, 0);
      vecs[3]  = row(1,  4, 1, 0, 1,  3, 2, 1);
      vecs[4]  = row(0,  0, 1, 0, 1,  3, 2, 1);
      vecs[5]  = row(0,  0, 0, 0, 1,  4, 1, 0);
      vecs[6]  = row(0,  0, 0, 0, 0,  0, 0, 0);
      vecs[7]  = row(1,  1, 1, 0, 1,  1, 1, 0);
      vecs[8]  = row(1,  2, 1, 0, 1,  1, 2, 1);
      vecs[9]  = row(1,  5, 0, 0, 1,  2, 1, 0);
      vecs[10] = row(0,  0, 0, 0, 0,  0, 0, 0);
      vecs[11] = row(1,  6, 1, 0, 1,  6, 1, 0);
      vecs[12] = row(1,  7, 1, 0, 1,  6, 2, 1);
      vecs[13] = row(1,  9, 1, 1, 0,  0, 0, 0);
      vecs[14] = row(0,  0, 0, 0, 0,  0, 0, 0);
      vecs[15] = row(1, 10, 0, 1, 0,  0, 0, 0);
      vecs[16] = row(1, 11, 0, 0, 1, 11, 1, 0);
      vecs[17] = row(1, 12, 0, 0, 1, 12, 1, 0);
      vecs[18] = row(0,  0, 0, 0, 0,  0, 0, 0);
      vecs[19] = row(1, 13, 1, 0, 1, 13, 1, 0);
      vecs[20] = row(0,  0, 0, 1, 0,  0, 0, 0);

      drive(1'b0, 6'd0, 1'b0, 1'b0);
      #3;
      check_pkt("reset_out", ex_cp_packet_out, '0);
      check_int("reset_stall", int'(stall_out), 0);
      check_int("reset_count", int'(count_out), 0);
      #9 reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         drive(vecs[i].in_valid, vecs[i].in_tag, vecs[i].cp_stall, vecs[i].squash);
         @(posedge clock);
         #1;
         check_pkt($sformatf("vec%0d_out", i), ex_cp_packet_out,
                   vecs[i].exp_valid ? make_pkt(vecs[i].exp_tag) : '0);
         check_int($sformatf("vec%0d_count", i), int'(count_out), int'(vecs[i].exp_count));
         check_int($sformatf("vec%0d_stall", i), int'(stall_out), int'(vecs[i].exp_stall));
      end

      // asynchronous reset with two entries held
      drive(1'b1, 6'd20, 1'b1, 1'b0);
      @(posedge clock); #1;
      drive(1'b1, 6'd21, 1'b1, 1'b0);
      @(posedge clock); #1;
      check_int("prereset_count", int'(count_out), 2);
      drive(1'b0, 6'd0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_pkt("midreset_out", ex_cp_packet_out, '0);
      check_int("midreset_stall", int'(stall_out), 0);
      check_int("midreset_count", int'(count_out), 0);
      #1 reset = 1'b0;
      @(posedge clock); #1;
      check_pkt("postreset_out", ex_cp_packet_out, '0);
      check_int("postreset_count", int'(count_out), 0);

      // stream tags 1..8 with the stall toggling every cycle
      popped    = 0;
      next_tag  = 1;
      model_cnt = 0;
      cyc       = 0;
      while (popped < 8 && cyc < 100) begin
         cp_stall_in = cyc[0];
         squash_in   = 1'b0;
         enq = (next_tag <= 8) && (model_cnt < DEPTH);
         ex_packet_in = enq ? make_pkt(6'(next_tag)) : '0;
         deq = (model_cnt > 0) && !cp_stall_in;
         if (model_cnt > 0) begin
            check_pkt("stream_head", ex_cp_packet_out, make_pkt(exp_q[0]));
         end else begin
            check_pkt("stream_empty", ex_cp_packet_out, '0);
         end
         if (deq) begin
            void'(exp_q.pop_front());
            popped++;
         end
         if (enq) begin
            exp_q.push_back(6'(next_tag));
            next_tag++;
         end
         model_cnt = model_cnt + int'(enq) - int'(deq);
         @(posedge clock); #1;
         check_int("stream_count", int'(count_out), model_cnt);
         check_int("stream_stall", int'(stall_out), int'(model_cnt == DEPTH));
         cyc++;
      end
      drive(1'b0, 6'd0, 1'b0, 1'b0);
      check_int("stream_popped", popped, 8);
      check_int("stream_leftover", exp_q.size(), 0);
      @(posedge clock); #1;
      check_pkt("stream_drained", ex_cp_packet_out, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
